// File: rtl/stage_four_mem.sv
// MEM stage of a 5-stage MIPS pipeline: word-addressed data memory plus the MEM/WB register.
// Optional byte/half access is enabled by defining SUBWORD_ACCESS_EN.
module stage_four_mem #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [4:0]  writeregister,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        MemToReg,
`ifdef SUBWORD_ACCESS_EN
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
`endif
  output logic [31:0] alu_result_out,
  output logic [31:0] memout,
  output logic [4:0]  writeregister_out,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic        misaligned
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] w_index;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_load;
  logic [31:0]       w_wdata;
  logic [31:0]       w_memout_nxt;
  logic [3:0]        w_be;
  logic              w_access;
  logic              w_misaligned;
  logic              w_store;
  logic              w_unused;

  // Upper address bits are deliberately ignored so the memory wraps.
  assign w_index   = alu_result[ADDR_W+1:2];
  assign w_unused  = &{1'b0, alu_result[31:ADDR_W+2]};
  assign w_rd_word = r_mem[w_index];
  assign w_access  = MemRead | MemWrite;

`ifdef SUBWORD_ACCESS_EN
  logic [15:0] w_lane;

  assign w_lane = 16'(w_rd_word >> {alu_result[1:0], 3'b000});

  // Byte-enable, store-data replication, load extraction and alignment per access size.
  always_comb begin
    w_be         = 4'b1111;
    w_wdata      = write_data;
    w_load       = w_rd_word;
    w_misaligned = 1'b0;
    case (mem_size)
      2'b00: begin
        w_be    = 4'b0001 << alu_result[1:0];
        w_wdata = {4{write_data[7:0]}};
        w_load  = mem_unsigned ? {24'h000000, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
      end
      2'b01: begin
        w_be         = alu_result[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{write_data[15:0]}};
        w_load       = mem_unsigned ? {16'h0000, w_lane} : {{16{w_lane[15]}}, w_lane};
        w_misaligned = w_access & alu_result[0];
      end
      default: begin
        w_misaligned = w_access & (alu_result[1:0] != 2'b00);
      end
    endcase
  end
`else
  assign w_be         = 4'b1111;
  assign w_wdata      = write_data;
  assign w_load       = w_rd_word;
  assign w_misaligned = w_access & (alu_result[1:0] != 2'b00);
`endif

  assign w_store = MemWrite & ~w_misaligned & ~reset & ~flush & ~stall;

  // Next memout value; a read+write combination returns the store data.
  always_comb begin
    w_memout_nxt = 32'h0000_0000;
    if (w_misaligned) begin
      w_memout_nxt = 32'h0000_0000;
    end else if (MemWrite && MemRead) begin
      w_memout_nxt = write_data;
    end else if (MemRead) begin
      w_memout_nxt = w_load;
    end else begin
      w_memout_nxt = 32'h0000_0000;
    end
  end

  // Data memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_index][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  // MEM/WB pipeline register: reset > flush > stall > normal.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      alu_result_out    <= 32'h0000_0000;
      memout            <= 32'h0000_0000;
      writeregister_out <= 5'd0;
      RegWrite_out      <= 1'b0;
      MemToReg_out      <= 1'b0;
      misaligned        <= 1'b0;
    end else if (!stall) begin
      alu_result_out    <= alu_result;
      memout            <= w_memout_nxt;
      writeregister_out <= writeregister;
      RegWrite_out      <= RegWrite & ~w_misaligned;
      MemToReg_out      <= MemToReg;
      misaligned        <= w_misaligned;
    end
  end

endmodule

// File: tb/tb_stage_four_mem.sv
// Scoreboard bench for stage_four_mem: the driver queues hand-computed MEM/WB values,
// a negedge monitor pops and compares them.
module tb_stage_four_mem;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] alu_result, write_data;
  logic [4:0]  writeregister;
  logic        MemRead, MemWrite, RegWrite, MemToReg;
`ifdef SUBWORD_ACCESS_EN
  logic [1:0]  mem_size = 2'b10;
  logic        mem_unsigned = 1'b0;
`endif
  logic [31:0] alu_result_out, memout;
  logic [4:0]  writeregister_out;
  logic        RegWrite_out, MemToReg_out, misaligned;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  wr;
    logic        rw;
    logic        m2r;
    logic        mis;
    int          tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   step_no = 0;

  stage_four_mem #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .alu_result(alu_result), .write_data(write_data), .writeregister(writeregister),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemToReg(MemToReg),
`ifdef SUBWORD_ACCESS_EN
    .mem_size(mem_size), .mem_unsigned(mem_unsigned),
`endif
    .alu_result_out(alu_result_out), .memout(memout), .writeregister_out(writeregister_out),
    .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then queue the MEM/WB values expected after that edge.
  task automatic step(input logic s_rst, input logic s_stl, input logic s_fl,
                      input logic [31:0] s_alu, input logic [31:0] s_wd, input logic [4:0] s_wr,
                      input logic s_mr, input logic s_mw, input logic s_rw, input logic s_m2r,
                      input logic [31:0] e_alu, input logic [31:0] e_mem, input logic [4:0] e_wr,
                      input logic e_rw, input logic e_m2r, input logic e_mis);
    exp_t e;
    reset = s_rst; stall = s_stl; flush = s_fl;
    alu_result = s_alu; write_data = s_wd; writeregister = s_wr;
    MemRead = s_mr; MemWrite = s_mw; RegWrite = s_rw; MemToReg = s_m2r;
    @(posedge clk);
    step_no++;
    e.alu = e_alu; e.mem = e_mem; e.wr = e_wr; e.rw = e_rw; e.m2r = e_m2r; e.mis = e_mis;
    e.tag = step_no;
    q.push_back(e);
    #1;
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (alu_result_out !== e.alu || memout !== e.mem || writeregister_out !== e.wr ||
          RegWrite_out !== e.rw || MemToReg_out !== e.m2r || misaligned !== e.mis) begin
        failures++;
        $display("FAIL memwb_step%0d got alu=%h mem=%h wr=%0d rw=%b m2r=%b mis=%b expected alu=%h mem=%h wr=%0d rw=%b m2r=%b mis=%b",
                 e.tag, alu_result_out, memout, writeregister_out, RegWrite_out, MemToReg_out, misaligned,
                 e.alu, e.mem, e.wr, e.rw, e.m2r, e.mis);
      end
    end
  end

  initial begin
    //    rst   stl   fl    alu            wd             wr     mr    mw    rw    m2r   | e_alu        e_mem          e_wr  rw    m2r   mis
    step(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0,  32'h0,        32'h0,         5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0,  32'h10,       32'h0,         5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0000_5555, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0,  32'h20,       32'h0,         5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 5'd5,  1'b1, 1'b0, 1'b1, 1'b1,  32'h10,       32'hDEAD_BEEF, 5'd5, 1'b1, 1'b1, 1'b0);
    // stalled cycles hold the previous load's outputs
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 32'h0000_0014, 32'h0000_0000, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0,   32'h10,       32'hDEAD_BEEF, 5'd5, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_1234, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0,  32'h10,       32'hDEAD_BEEF, 5'd5, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0000_0000, 5'd8,  1'b1, 1'b0, 1'b1, 1'b1,  32'h20,       32'h0000_5555, 5'd8, 1'b1, 1'b1, 1'b0);
    // flush kills a store
    step(1'b0, 1'b0, 1'b0, 32'h0000_0030, 32'h1111_2222, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0,  32'h30,       32'h0,         5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0030, 32'hAAAA_5555, 5'd3,  1'b0, 1'b1, 1'b1, 1'b0,  32'h0,        32'h0,         5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0000_0030, 32'h0000_0000, 5'd3,  1'b1, 1'b0, 1'b1, 1'b1,  32'h30,       32'h1111_2222, 5'd3, 1'b1, 1'b1, 1'b0);
    // misaligned load and store
    step(1'b0, 1'b0, 1'b0, 32'h0000_0013, 32'h0000_0000, 5'd4,  1'b1, 1'b0, 1'b1, 1'b1,  32'h13,       32'h0,         5'd4, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0000_0022, 32'h0000_0001, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0,  32'h22,       32'h0,         5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0000_0000, 5'd6,  1'b1, 1'b0, 1'b1, 1'b1,  32'h20,       32'h0000_5555, 5'd6, 1'b1, 1'b1, 1'b0);
    // address wrap: 0x400 aliases word 0
    step(1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_0077, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0,  32'h400,      32'h0,         5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd2,  1'b1, 1'b0, 1'b1, 1'b1,  32'h0,        32'h0000_0077, 5'd2, 1'b1, 1'b1, 1'b0);
    // read+write together stores and returns write_data
    step(1'b0, 1'b0, 1'b0, 32'h0000_0050, 32'hCAFE_F00D, 5'd9,  1'b1, 1'b1, 1'b1, 1'b0,  32'h50,       32'hCAFE_F00D, 5'd9, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0000_0050, 32'h0000_0000, 5'd9,  1'b1, 1'b0, 1'b1, 1'b1,  32'h50,       32'hCAFE_F00D, 5'd9, 1'b1, 1'b1, 1'b0);
    // ALU op without memory access: unaligned address is fine
    step(1'b0, 1'b0, 1'b0, 32'h0000_0123, 32'hFFFF_FFFF, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0,  32'h123,      32'h0,         5'd10,1'b1, 1'b0, 1'b0);
    // reset during stall wins and blocks the store
    step(1'b1, 1'b1, 1'b0, 32'h0000_0050, 32'h0000_0099, 5'd1,  1'b0, 1'b1, 1'b1, 1'b0,  32'h0,        32'h0,         5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0000_0050, 32'h0000_0000, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1,  32'h50,       32'hCAFE_F00D, 5'd11,1'b1, 1'b1, 1'b0);
    // back-to-back store then load
    step(1'b0, 1'b0, 1'b0, 32'h0000_0060, 32'h0BAD_F00D, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0,  32'h60,       32'h0,         5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0000_0060, 32'h0000_0000, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1,  32'h60,       32'h0BAD_F00D, 5'd12,1'b1, 1'b1, 1'b0);
    // flush beats stall
    step(1'b0, 1'b1, 1'b1, 32'h0000_0060, 32'h0000_0000, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1,  32'h0,        32'h0,         5'd0, 1'b0, 1'b0, 1'b0);
`ifdef SUBWORD_ACCESS_EN
    mem_size = 2'b10;
    step(1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0000, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0,  32'h40,       32'h0,         5'd0, 1'b0, 1'b0, 1'b0);
    mem_size = 2'b00;
    step(1'b0, 1'b0, 1'b0, 32'h0000_0041, 32'h0000_0080, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0,  32'h41,       32'h0,         5'd0, 1'b0, 1'b0, 1'b0);
    mem_unsigned = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'h0000_0041, 32'h0000_0000, 5'd1,  1'b1, 1'b0, 1'b1, 1'b1,  32'h41,       32'hFFFF_FF80, 5'd1, 1'b1, 1'b1, 1'b0);
    mem_unsigned = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0000_0041, 32'h0000_0000, 5'd1,  1'b1, 1'b0, 1'b1, 1'b1,  32'h41,       32'h0000_0080, 5'd1, 1'b1, 1'b1, 1'b0);
    mem_size = 2'b10; mem_unsigned = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0000, 5'd1,  1'b1, 1'b0, 1'b1, 1'b1,  32'h40,       32'h0000_8000, 5'd1, 1'b1, 1'b1, 1'b0);
    mem_size = 2'b01;
    step(1'b0, 1'b0, 1'b0, 32'h0000_0041, 32'h0000_0000, 5'd1,  1'b1, 1'b0, 1'b1, 1'b1,  32'h41,       32'h0,         5'd1, 1'b0, 1'b1, 1'b1);
    mem_size = 2'b10;
`endif
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending entries, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_four_mem.md
Name: stage_four_mem

Overview:
- Memory-access stage of the 5-stage MIPS pipeline, directly upstream of the writeback stage.
- Holds word-addressed data memory and performs loads and stores using the EX-stage ALU result as the address.
- Registers results into the MEM/WB pipeline register. Its outputs feed the writeback mux inputs (alu_result, memout, writeregister, RegWrite, MemToReg) one cycle later.

Parameters:
- ADDR_W, 8: word-address width; data memory holds 2**ADDR_W 32-bit words.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears the MEM/WB register
- stall  input  1  hold the MEM/WB register; block stores
- flush  input  1  kill the instruction currently in MEM; insert a bubble
- alu_result  input  32  EX result / memory byte address
- write_data  input  32  store data (rt value)
- writeregister  input  5  destination register
- MemRead  input  1  load enable
- MemWrite  input  1  store enable
- RegWrite  input  1  register-write control
- MemToReg  input  1  writeback select (1 = memory data)
- alu_result_out  output  32  registered alu_result
- memout  output  32  registered load data
- writeregister_out  output  5  registered destination
- RegWrite_out  output  1  registered RegWrite (qualified)
- MemToReg_out  output  1  registered MemToReg
- misaligned  output  1  registered flag: the last accepted access was misaligned

Behaviour:
- Word index = alu_result[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 2**ADDR_W words.
- Latency: 1 cycle from inputs to MEM/WB outputs. Memory read is synchronous; load data appears on memout the cycle after MemRead.
- Priority per edge: reset > flush > stall > normal.
- Reset: all MEM/WB outputs go to 0 (alu_result_out, memout, writeregister_out, RegWrite_out, MemToReg_out, misaligned). Memory contents are not cleared. A reset mid-stall or mid-flush wins and no store occurs that cycle.
- Flush: no store. RegWrite_out=0, MemToReg_out=0, misaligned=0, and memout/alu_result_out/writeregister_out go to 0 (bubble).
- Stall, no flush: all MEM/WB outputs hold their values and no store occurs. A held instruction re-executes when stall drops.
- Normal: alu_result_out<=alu_result, writeregister_out<=writeregister, MemToReg_out<=MemToReg.
- Misaligned access (MemRead|MemWrite with alu_result[1:0]!=0):
  - misaligned<=1, the store is suppressed, and RegWrite_out<=0.
  - memout<=0.
  - Otherwise misaligned<=0 and RegWrite_out<=RegWrite.
- Store (MemWrite, aligned): the memory word is written with write_data at the edge.
- Load (MemRead, aligned, MemWrite=0): memout<=mem[index], the old contents.
- MemRead and MemWrite both set is an illegal combination. The block performs the write and memout<=write_data.
- Neither MemRead nor MemWrite: memout<=0 and memory is untouched.
- Back-to-back store then load to the same address in consecutive cycles: the load returns the stored data. The write has committed at the earlier edge, so no bypass is needed.

Optional Feature:
- Macro SUBWORD_ACCESS_EN.
- Defined: adds input mem_size[1:0] (00 byte, 01 half, 10 word) and input mem_unsigned.
  - Stores use byte enables: SB writes the byte lane alu_result[1:0]; SH writes the half lane alu_result[1].
  - Loads extract the lane and sign- or zero-extend per mem_unsigned.
  - Alignment check: half requires alu_result[0]=0; byte is always aligned.
- Undefined: ports absent; word-only access; any nonzero alu_result[1:0] is misaligned.

Test Plan:
- Reset, then store 0xDEADBEEF at 0x10, then load 0x10 with MemToReg=1, writeregister=5 -> next cycle memout=0xDEADBEEF, writeregister_out=5, RegWrite_out=1.
- Load to 0x10 with stall=1 for 3 cycles -> outputs hold their pre-stall values. Store with stall=1 at 0x20 of 0x1234, then load 0x20 -> returns the prior contents, not 0x1234.
- flush=1 on a store of 0xAAAA5555 to 0x30 with RegWrite=1 -> RegWrite_out=0, memout=0, and a later load of 0x30 returns the old value.
- Load from 0x13 -> misaligned=1, RegWrite_out=0, memout=0. Store of 0x1 to 0x22 -> memory unchanged.
- With ADDR_W=8, store 0x77 at 0x400 then load 0x0 -> 0x77 (wrap). Assert reset during stall -> all outputs 0 on the next edge.
- With SUBWORD_ACCESS_EN: write word 0x00000000 to 0x40, then SB 0x80 at 0x41.
  - Signed LB 0x41 -> 0xFFFFFF80.
  - Unsigned LB -> 0x00000080.
  - LW 0x40 -> 0x00008000.
